// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge
// Brief    : CPU bus bridge to RAM, UART TX FIFO / RX, cycle counter and
//            program-stop. Optional UART RX path enabled by IO_BRIDGE_RX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module io_bridge #(
    parameter int TX_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a_in,
    input  logic [7:0]  cpu_dout_in,
    input  logic        cpu_wr_in,
    output logic [7:0]  cpu_din_out,
    output logic        cpu_rdy_out,
    output logic [16:0] ram_a_out,
    output logic [7:0]  ram_din_out,
    output logic        ram_we_out,
    input  logic [7:0]  ram_dout_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic        stop_out
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] c_selZero = 2'd0;
    localparam logic [1:0] c_selRam  = 2'd1;
    localparam logic [1:0] c_selRx   = 2'd2;
    localparam logic [1:0] c_selCnt  = 2'd3;

    localparam logic [CW-1:0] c_rdyLimit = CW'(TX_DEPTH - 2);

    logic          r_rdy;
    logic          r_stopPend;
    logic          r_stop;
    logic          r_cntRun;
    logic [31:0]   r_counter;
    logic [31:0]   r_snap;
    logic [1:0]    r_sel;
    logic [1:0]    r_byte;
    logic [7:0]    r_mem [TX_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic          w_valid;
    logic          w_rd;
    logic          w_wr;
    logic          w_ramSel;
    logic          w_ioSel;
    logic          w_uartSel;
    logic          w_ctlSel;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_cntRead;
    logic          w_stopPendNext;
    logic [CW-1:0] w_countNext;
    logic [1:0]    w_selNext;
    logic          w_unusedBits;

    // The core only commits an access in a cycle where it sees ready high.
    assign w_valid   = r_rdy;
    assign w_rd      = w_valid & ~cpu_wr_in;
    assign w_wr      = w_valid & cpu_wr_in;
    assign w_ramSel  = ~cpu_a_in[17];
    assign w_ioSel   = &cpu_a_in[17:16];
    assign w_uartSel = w_ioSel & ~cpu_a_in[2];
    assign w_ctlSel  = w_ioSel & cpu_a_in[2];
    assign w_cntRead = w_rd & w_ctlSel & (cpu_a_in[1:0] == 2'd0);

    assign ram_a_out   = cpu_a_in[16:0];
    assign ram_din_out = cpu_dout_in;
    assign ram_we_out  = w_wr & w_ramSel;

    assign w_empty        = (r_count == '0);
    assign w_push         = w_wr & w_uartSel & (cpu_dout_in != 8'h00);
    assign w_pop          = ~w_empty & tx_ready_in;
    assign w_countNext    = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    assign w_stopPendNext = r_stopPend | (w_wr & w_ctlSel);

    assign tx_valid_out = ~w_empty;
    assign tx_data_out  = r_mem[r_rdPtr];
    assign cpu_rdy_out  = r_rdy;
    assign stop_out     = r_stop;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= cpu_dout_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_rdy      <= 1'b0;
            r_stopPend <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count    <= w_countNext;
            r_stopPend <= w_stopPendNext;
            // Ready leaves one slot of headroom so an accepted write always fits.
            r_rdy      <= (w_countNext <= c_rdyLimit) & ~w_stopPendNext;
            r_stop     <= r_stop | (w_stopPendNext & (w_countNext == '0));
        end
    end

    // The counter holds 0 through the first cycle after release, then runs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cntRun  <= 1'b0;
            r_counter <= '0;
            r_snap    <= '0;
        end else begin
            r_cntRun <= 1'b1;
            if (r_cntRun) begin
                r_counter <= r_counter + 32'd1;
            end
            if (w_cntRead) begin
                r_snap <= r_counter;
            end
        end
    end

    always_comb begin
        w_selNext = c_selZero;
        if (w_rd) begin
            if (w_ramSel) begin
                w_selNext = c_selRam;
            end else if (w_ctlSel) begin
                w_selNext = c_selCnt;
            end else if (w_uartSel) begin
`ifdef IO_BRIDGE_RX_EN
                w_selNext = c_selRx;
`else
                w_selNext = c_selZero;
`endif
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel  <= c_selZero;
            r_byte <= 2'd0;
        end else begin
            r_sel  <= w_selNext;
            r_byte <= cpu_a_in[1:0];
        end
    end

`ifdef IO_BRIDGE_RX_EN
    logic [7:0] r_rxByte;

    assign rx_ready_out = w_rd & w_uartSel & rx_valid_in;

    // RX head is captured now because the pop strobe advances it this cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rxByte <= 8'h00;
        end else if (w_rd & w_uartSel) begin
            r_rxByte <= rx_valid_in ? rx_data_in : 8'h00;
        end
    end

    assign w_unusedBits = ^cpu_a_in[31:18];
`else
    assign rx_ready_out = 1'b0;
    assign w_unusedBits = ^{cpu_a_in[31:18], rx_data_in, rx_valid_in};
`endif

    always_comb begin
        cpu_din_out = 8'h00;
        case (r_sel)
            c_selRam: cpu_din_out = ram_dout_in;
`ifdef IO_BRIDGE_RX_EN
            c_selRx:  cpu_din_out = r_rxByte;
`endif
            c_selCnt: cpu_din_out = r_snap[8*r_byte +: 8];
            default:  cpu_din_out = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bridge
// Brief    : Directed self-checking bench for io_bridge (honours IO_BRIDGE_RX_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpuA;
    logic [7:0]  cpuDout;
    logic        cpuWr;
    logic [7:0]  cpuDin;
    logic        cpuRdy;
    logic [16:0] ramA;
    logic [7:0]  ramDin;
    logic        ramWe;
    logic [7:0]  ramDout = 8'h00;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        stop;

    int tests  = 0;
    int failed = 0;

    logic [7:0] ramModel [4096];
    logic [7:0] popLog [64];
    int         popCnt = 0;

    always #5 clk = ~clk;

    io_bridge #(.TX_DEPTH(16)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .cpu_a_in     (cpuA),
        .cpu_dout_in  (cpuDout),
        .cpu_wr_in    (cpuWr),
        .cpu_din_out  (cpuDin),
        .cpu_rdy_out  (cpuRdy),
        .ram_a_out    (ramA),
        .ram_din_out  (ramDin),
        .ram_we_out   (ramWe),
        .ram_dout_in  (ramDout),
        .rx_data_in   (rxData),
        .rx_valid_in  (rxValid),
        .rx_ready_out (rxReady),
        .tx_data_out  (txData),
        .tx_valid_out (txValid),
        .tx_ready_in  (txReady),
        .stop_out     (stop)
    );

    // Registered-read RAM model.
    always @(posedge clk) begin
        if (ramWe) ramModel[ramA[11:0]] <= ramDin;
        ramDout <= ramModel[ramA[11:0]];
    end

    always @(posedge clk) begin
        if (!rst && txValid && txReady && popCnt < 64) begin
            popLog[popCnt] <= txData;
            popCnt <= popCnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cpuA = 32'h0002_0000;
        cpuDout = 8'h00;
        cpuWr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the following cycle.
    task automatic access(input logic [31:0] a, input logic [7:0] d, input logic wr);
        int guard = 0;
        while (cpuRdy !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("rdyWait", {31'b0, cpuRdy}, 32'd1);
        cpuA = a;
        cpuDout = d;
        cpuWr = wr;
        @(negedge clk);
        idle();
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int guard;
        logic [7:0] rxExp;
        logic       rxRdyExp;

`ifdef IO_BRIDGE_RX_EN
        rxExp = 8'h31;
        rxRdyExp = 1'b1;
`else
        rxExp = 8'h00;
        rxRdyExp = 1'b0;
`endif
        rst = 1'b1;
        idle();
        rxData = 8'h00;
        rxValid = 1'b0;
        txReady = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rstRdy", {31'b0, cpuRdy}, 32'd0);
        check("rstDin", {24'b0, cpuDin}, 32'h00);
        check("rstTxValid", {31'b0, txValid}, 32'd0);
        check("rstStop", {31'b0, stop}, 32'd0);
        check("rstRamWe", {31'b0, ramWe}, 32'd0);
        check("rstRxReady", {31'b0, rxReady}, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("rdyAfterRelease", {31'b0, cpuRdy}, 32'd1);

        // Counter reads 0xFF at the 0x30004 read; upper bytes must come from the snapshot
        repeat (255) @(negedge clk);
        access(32'h0003_0004, 8'h00, 1'b0);
        check("cntByte0", {24'b0, cpuDin}, 32'hFF);
        access(32'h0003_0005, 8'h00, 1'b0);
        check("cntByte1", {24'b0, cpuDin}, 32'h00);
        access(32'h0003_0006, 8'h00, 1'b0);
        check("cntByte2", {24'b0, cpuDin}, 32'h00);
        access(32'h0003_0007, 8'h00, 1'b0);
        check("cntByte3", {24'b0, cpuDin}, 32'h00);
        access(32'h0003_0004, 8'h00, 1'b0);
        check("cnt2Byte0", {24'b0, cpuDin}, 32'h03);
        access(32'h0003_0005, 8'h00, 1'b0);
        check("cnt2Byte1", {24'b0, cpuDin}, 32'h01);

        // RAM write then read
        cpuA = 32'h0000_0123; cpuDout = 8'h5A; cpuWr = 1'b1;
        #1;
        check("ramWeWrite", {31'b0, ramWe}, 32'd1);
        check("ramAddr", {15'b0, ramA}, 32'h0_0123);
        check("ramDin", {24'b0, ramDin}, 32'h5A);
        @(negedge clk);
        cpuWr = 1'b0;
        #1;
        check("ramWeRead", {31'b0, ramWe}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("ramReadData", {24'b0, cpuDin}, 32'h5A);

        // Hole: write dropped, read returns zero
        cpuA = 32'h0002_0123; cpuDout = 8'h77; cpuWr = 1'b1;
        #1;
        check("holeWe", {31'b0, ramWe}, 32'd0);
        @(negedge clk);
        idle();
        access(32'h0002_0123, 8'h00, 1'b0);
        check("holeRead", {24'b0, cpuDin}, 32'h00);
        access(32'h0000_0123, 8'h00, 1'b0);
        check("ramKeep", {24'b0, cpuDin}, 32'h5A);

        // Zero byte to UART is ignored
        access(32'h0003_0000, 8'h00, 1'b1);
        check("zeroTxValid", {31'b0, txValid}, 32'd0);
        @(negedge clk);
        check("zeroTxValid2", {31'b0, txValid}, 32'd0);

        // Fill TX FIFO with 'A'..'O'; ready must drop after the 15th push
        base = popCnt;
        for (int i = 0; i < 15; i++) begin
            access(32'h0003_0000, 8'h41 + 8'(i), 1'b1);
            if (i == 13) check("rdyAt14", {31'b0, cpuRdy}, 32'd1);
        end
        check("rdyAt15", {31'b0, cpuRdy}, 32'd0);
        check("txHeadA", {24'b0, txData}, 32'h41);
        check("txValidFull", {31'b0, txValid}, 32'd1);
        txReady = 1'b1;
        @(negedge clk);
        #1;
        check("rdyReturn", {31'b0, cpuRdy}, 32'd1);
        check("txHeadB", {24'b0, txData}, 32'h42);
        access(32'h0003_0000, 8'h50, 1'b1);
        guard = 0;
        while (txValid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drainTxValid", {31'b0, txValid}, 32'd0);
        check("popCount16", popCnt - base, 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("popOrder", {24'b0, popLog[base + i]}, 32'h41 + i);
        end

        // UART RX read with and without a byte available
        rxValid = 1'b1;
        rxData = 8'h31;
        cpuA = 32'h0003_0000; cpuWr = 1'b0;
        #1;
        check("rxReadyPulse", {31'b0, rxReady}, {31'b0, rxRdyExp});
        @(negedge clk);
        idle();
        #1;
        check("rxData", {24'b0, cpuDin}, {24'b0, rxExp});
        check("rxReadyLow", {31'b0, rxReady}, 32'd0);
        rxValid = 1'b0;
        cpuA = 32'h0003_0000; cpuWr = 1'b0;
        #1;
        check("rxNoPulse", {31'b0, rxReady}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("rxEmptyData", {24'b0, cpuDin}, 32'h00);

        // Stop waits for "hi" to drain
        txReady = 1'b0;
        base = popCnt;
        access(32'h0003_0000, 8'h68, 1'b1);
        access(32'h0003_0000, 8'h69, 1'b1);
        access(32'h0003_0004, 8'h99, 1'b1);
        check("stopRdyLow", {31'b0, cpuRdy}, 32'd0);
        check("stopHeld", {31'b0, stop}, 32'd0);
        repeat (3) @(negedge clk);
        check("stopHeld2", {31'b0, stop}, 32'd0);
        txReady = 1'b1;
        @(negedge clk);
        check("stopBeforeI", {31'b0, stop}, 32'd0);
        check("txHeadI", {24'b0, txData}, 32'h69);
        @(negedge clk);
        check("stopRise", {31'b0, stop}, 32'd1);
        check("stopTxEmpty", {31'b0, txValid}, 32'd0);
        repeat (5) @(negedge clk);
        check("stopSticky", {31'b0, stop}, 32'd1);
        check("stopRdySticky", {31'b0, cpuRdy}, 32'd0);
        check("hiPops", {24'b0, popLog[base]}, 32'h68);
        check("hiPops2", {24'b0, popLog[base + 1]}, 32'h69);

        // Reset clears stop; then reset mid-operation discards FIFO and in-flight read
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstClearsStop", {31'b0, stop}, 32'd0);
        check("rstRdyBack", {31'b0, cpuRdy}, 32'd1);
        txReady = 1'b0;
        access(32'h0003_0000, 8'h78, 1'b1);
        access(32'h0003_0000, 8'h79, 1'b1);
        cpuA = 32'h0000_0123; cpuWr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        idle();
        #1;
        check("inflightRead", {24'b0, cpuDin}, 32'h00);
        check("rstFifoEmpty", {31'b0, txValid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        base = popCnt;
        txReady = 1'b1;
        access(32'h0003_0000, 8'h7A, 1'b1);
        check("postRstHead", {24'b0, txData}, 32'h7A);
        @(negedge clk);
        check("postRstPops", popCnt - base, 32'd1);
        check("postRstEmpty", {31'b0, txValid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
